// File: rtl/pulse_stretch_core.sv
`default_nettype none
// ============================================================================
// pulse_stretch_core : rising-edge triggered pulse stretcher with programmable
//                      delay/width and accepted/missed trigger counters.
// Revision: 1.0
// ============================================================================
module pulse_stretch_core #(
  parameter int WIDTH_BITS = 12,
  parameter int DELAY_BITS = 4,
  parameter bit RETRIGGER  = 1'b0
) (
  input  logic        CLK1,
  input  logic        RESET_N,
  input  logic [15:0] CONFIG_IN,
  input  logic        PULSE_IN,
  output logic        PULSE_OUT,
  output logic        BUSY,
  output logic [15:0] TRIG_COUNT,
  output logic [15:0] MISS_COUNT
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DELAY   = 2'd1,
    S_STRETCH = 2'd2
  } state_t;

  localparam logic [WIDTH_BITS-1:0] W_ONE = {{(WIDTH_BITS-1){1'b0}}, 1'b1};
  localparam logic [DELAY_BITS-1:0] D_ONE = {{(DELAY_BITS-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic                  pulse_prev_q;
  logic [WIDTH_BITS-1:0] w_snap_q, w_snap_d;
  logic [WIDTH_BITS-1:0] w_cnt_q, w_cnt_d;
  logic [DELAY_BITS-1:0] d_cnt_q, d_cnt_d;
  logic                  out_q, out_d;
  logic                  busy_q, busy_d;
  logic [15:0]           trig_q, trig_d;
  logic [15:0]           miss_q, miss_d;
  logic                  miss_inc;
  logic                  rise;
  logic [WIDTH_BITS-1:0] cfg_w;
  logic [DELAY_BITS-1:0] cfg_d;

  assign cfg_w = CONFIG_IN[WIDTH_BITS-1:0];
  assign cfg_d = CONFIG_IN[WIDTH_BITS+DELAY_BITS-1:WIDTH_BITS];
  assign rise  = PULSE_IN & ~pulse_prev_q;

  // Both counters hold "cycles remaining minus one", so a zero count marks the final edge.
  always_comb begin
    state_d  = state_q;
    w_snap_d = w_snap_q;
    w_cnt_d  = w_cnt_q;
    d_cnt_d  = d_cnt_q;
    out_d    = 1'b0;
    trig_d   = trig_q;
    miss_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise && (cfg_w != '0)) begin
          w_snap_d = cfg_w;
          w_cnt_d  = cfg_w - W_ONE;
          trig_d   = trig_q + 16'd1;
          if (cfg_d == '0) begin
            state_d = S_STRETCH;
            out_d   = 1'b1;
          end else begin
            state_d = S_DELAY;
            d_cnt_d = cfg_d - D_ONE;
          end
        end
      end
      S_DELAY: begin
        miss_inc = rise;
        if (d_cnt_q == '0) begin
          state_d = S_STRETCH;
          out_d   = 1'b1;
        end else begin
          d_cnt_d = d_cnt_q - D_ONE;
        end
      end
      S_STRETCH: begin
        out_d = 1'b1;
        if (rise && RETRIGGER) begin
          w_cnt_d = w_snap_q - W_ONE;
          trig_d  = trig_q + 16'd1;
        end else begin
          miss_inc = rise;
          if (w_cnt_q == '0) begin
            state_d = S_IDLE;
            out_d   = 1'b0;
          end else begin
            w_cnt_d = w_cnt_q - W_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    miss_d = (miss_inc && (miss_q != 16'hFFFF)) ? miss_q + 16'd1 : miss_q;
    busy_d = (state_d != S_IDLE);
  end

  // Previous-input register resets high so a level held through reset is not a rise.
  always_ff @(posedge CLK1) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      pulse_prev_q <= 1'b1;
      w_snap_q     <= '0;
      w_cnt_q      <= '0;
      d_cnt_q      <= '0;
      out_q        <= 1'b0;
      busy_q       <= 1'b0;
      trig_q       <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      pulse_prev_q <= PULSE_IN;
      w_snap_q     <= w_snap_d;
      w_cnt_q      <= w_cnt_d;
      d_cnt_q      <= d_cnt_d;
      out_q        <= out_d;
      busy_q       <= busy_d;
      trig_q       <= trig_d;
      miss_q       <= miss_d;
    end
  end

  assign PULSE_OUT  = out_q;
  assign BUSY       = busy_q;
  assign TRIG_COUNT = trig_q;
  assign MISS_COUNT = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretch_core.sv
`default_nettype none
// ============================================================================
// tb_pulse_stretch_core : vector table + scoreboard bench, one DUT per
//                         RETRIGGER setting driven with identical stimulus.
// Revision: 1.0
// ============================================================================
module tb_pulse_stretch_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg;
  logic        pin;
  logic        out0, busy0, out1, busy1;
  logic [15:0] trig0, miss0, trig1, miss1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pulse_stretch_core #(.WIDTH_BITS(12), .DELAY_BITS(4), .RETRIGGER(1'b0)) dut0 (
    .CLK1(clk), .RESET_N(rst_n), .CONFIG_IN(cfg), .PULSE_IN(pin),
    .PULSE_OUT(out0), .BUSY(busy0), .TRIG_COUNT(trig0), .MISS_COUNT(miss0)
  );

  pulse_stretch_core #(.WIDTH_BITS(12), .DELAY_BITS(4), .RETRIGGER(1'b1)) dut1 (
    .CLK1(clk), .RESET_N(rst_n), .CONFIG_IN(cfg), .PULSE_IN(pin),
    .PULSE_OUT(out1), .BUSY(busy1), .TRIG_COUNT(trig1), .MISS_COUNT(miss1)
  );

  typedef struct {
    logic [15:0] cfg_a;
    logic [15:0] cfg_b;
    int          sw;
    logic [23:0] pat;
    logic [23:0] out0;
    logic [23:0] busy0;
    logic [23:0] out1;
    logic [23:0] busy1;
    int          dt0, dm0, dt1, dm1;
  } vec_t;

  typedef struct packed {
    logic o0, b0, o1, b1;
  } exp_t;

  vec_t        tbl[10];
  exp_t        sb[$];
  logic [15:0] et0, em0, et1, em1;

  function automatic logic [15:0] mk(input int d, input int w);
    logic [3:0]  dd;
    logic [11:0] ww;
    dd = d[3:0];
    ww = w[11:0];
    return {dd, ww};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, " trig0"}, trig0, et0);
    check({tag, " miss0"}, miss0, em0);
    check({tag, " trig1"}, trig1, et1);
    check({tag, " miss1"}, miss1, em1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    // cfg_a, cfg_b, switch cycle, pulse pattern, out0, busy0, out1, busy1, dt0, dm0, dt1, dm1
    tbl[0] = '{mk(0,5), mk(0,5), 99, 24'h000004, 24'h00007C, 24'h00007C, 24'h00007C, 24'h00007C, 1, 0, 1, 0};
    tbl[1] = '{mk(4,3), mk(4,3), 99, 24'h000014, 24'h0001C0, 24'h0001FC, 24'h0001C0, 24'h0001FC, 1, 1, 1, 1};
    tbl[2] = '{mk(0,4), mk(0,4), 99, 24'h000014, 24'h00003C, 24'h00003C, 24'h0000FC, 24'h0000FC, 1, 1, 2, 0};
    tbl[3] = '{mk(3,0), mk(3,0), 99, 24'h000004, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 0, 0, 0, 0};
    tbl[4] = '{mk(0,5), mk(0,9),  4, 24'h000004, 24'h00007C, 24'h00007C, 24'h00007C, 24'h00007C, 1, 0, 1, 0};
    tbl[5] = '{mk(0,3), mk(0,3), 99, 24'h000024, 24'h00001C, 24'h00001C, 24'h0000FC, 24'h0000FC, 1, 1, 2, 0};
    tbl[6] = '{mk(0,2), mk(0,2), 99, 24'h000024, 24'h00006C, 24'h00006C, 24'h00006C, 24'h00006C, 2, 0, 2, 0};
    tbl[7] = '{mk(15,1), mk(15,1), 99, 24'h000004, 24'h020000, 24'h03FFFC, 24'h020000, 24'h03FFFC, 1, 0, 1, 0};
    tbl[8] = '{mk(0,2), mk(0,2), 99, 24'h00003C, 24'h00000C, 24'h00000C, 24'h00000C, 24'h00000C, 1, 0, 1, 0};
    tbl[9] = '{mk(1,1), mk(1,1), 99, 24'h000004, 24'h000008, 24'h00000C, 24'h000008, 24'h00000C, 1, 0, 1, 0};

    // Reset with the input held high, then release with it still high: no trigger.
    rst_n = 1'b0;
    pin   = 1'b1;
    cfg   = mk(0, 5);
    step(); step(); step();
    check("reset out0", {15'd0, out0}, 16'd0);
    check("reset busy0", {15'd0, busy0}, 16'd0);
    check("reset busy1", {15'd0, busy1}, 16'd0);
    et0 = 16'd0; em0 = 16'd0; et1 = 16'd0; em1 = 16'd0;
    check_counts("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("held-high busy0 c%0d", i), {15'd0, busy0}, 16'd0);
      check($sformatf("held-high out1 c%0d", i), {15'd0, out1}, 16'd0);
    end
    check_counts("held-high");
    pin = 1'b0;
    step(); step();

    // Table-driven scenarios through the scoreboard.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 24; i++) begin
        cfg = (i >= tbl[t].sw) ? tbl[t].cfg_b : tbl[t].cfg_a;
        pin = tbl[t].pat[i];
        sb.push_back('{o0: tbl[t].out0[i], b0: tbl[t].busy0[i],
                       o1: tbl[t].out1[i], b1: tbl[t].busy1[i]});
        step();
        e = sb.pop_front();
        check($sformatf("v%0d c%0d out0", t, i), {15'd0, out0}, {15'd0, e.o0});
        check($sformatf("v%0d c%0d busy0", t, i), {15'd0, busy0}, {15'd0, e.b0});
        check($sformatf("v%0d c%0d out1", t, i), {15'd0, out1}, {15'd0, e.o1});
        check($sformatf("v%0d c%0d busy1", t, i), {15'd0, busy1}, {15'd0, e.b1});
      end
      et0 += 16'(tbl[t].dt0);
      em0 += 16'(tbl[t].dm0);
      et1 += 16'(tbl[t].dt1);
      em1 += 16'(tbl[t].dm1);
      check_counts($sformatf("v%0d", t));
    end

    // Reset in the middle of a stretch clears everything on that edge.
    cfg = mk(0, 10);
    pin = 1'b1;
    step();
    pin = 1'b0;
    step(); step();
    check("pre-reset out0", {15'd0, out0}, 16'd1);
    check("pre-reset busy1", {15'd0, busy1}, 16'd1);
    rst_n = 1'b0;
    step();
    check("mid-reset out0", {15'd0, out0}, 16'd0);
    check("mid-reset busy0", {15'd0, busy0}, 16'd0);
    check("mid-reset out1", {15'd0, out1}, 16'd0);
    check("mid-reset busy1", {15'd0, busy1}, 16'd0);
    et0 = 16'd0; em0 = 16'd0; et1 = 16'd0; em1 = 16'd0;
    check_counts("mid-reset");
    rst_n = 1'b1;
    step(); step();

    // Counter preload: trigger count wraps, miss count saturates.
    force dut0.trig_q = 16'hFFFF;
    force dut0.miss_q = 16'hFFFE;
    force dut1.trig_q = 16'hFFFF;
    force dut1.miss_q = 16'hFFFE;
    #1;
    release dut0.trig_q;
    release dut0.miss_q;
    release dut1.trig_q;
    release dut1.miss_q;
    cfg = mk(0, 8);
    for (int i = 0; i < 12; i++) begin
      pin = (i == 0 || i == 2 || i == 4 || i == 6);
      step();
      if (i == 0) begin
        check("wrap trig0", trig0, 16'h0000);
        check("wrap trig1", trig1, 16'h0000);
      end
      if (i == 4) check("sat miss0 after 2", miss0, 16'hFFFF);
    end
    et0 = 16'h0000; em0 = 16'hFFFF; et1 = 16'h0003; em1 = 16'hFFFE;
    check_counts("saturate");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
